// File: rtl/div_run_pkg.sv
// Shared types and constants for the divide-job sequencer that drives the
// TopLevel processor's data memory and start/halt handshake.
package div_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ,
    S_RESP
  } run_state_t;

  localparam logic [2:0] ADDR_DVD_HI = 3'd0;
  localparam logic [2:0] ADDR_DVD_LO = 3'd1;
  localparam logic [2:0] ADDR_DVS    = 3'd2;
  localparam logic [2:0] ADDR_Q0     = 3'd4;

  localparam logic [2:0] LOAD_LEN = 3'd6;
  localparam logic [2:0] READ_LEN = 3'd3;

  // Address 3 is skipped: the program keeps scratch state there.
  function automatic logic [2:0] loadAddr(input logic [2:0] step);
    case (step)
      3'd0:    return ADDR_DVD_HI;
      3'd1:    return ADDR_DVD_LO;
      3'd2:    return ADDR_DVS;
      default: return ADDR_Q0 + (step - 3'd3);
    endcase
  endfunction

endpackage

// File: rtl/div_run_ctrl_if.sv
// Job request, data-memory, processor control and response signals of the
// divide-job sequencer; master is the sequencer, slave is its environment.
interface div_run_ctrl_if #(parameter int MEM_AW = 8);

  logic              req_valid;
  logic              req_ready;
  logic [15:0]       dividend;
  logic [7:0]        divisor;
  logic              mem_sel;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              cpu_start;
  logic              cpu_halt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [23:0]       quotient;
  logic              err_div0;
  logic              err_timeout;

  modport master (
    input  req_valid, dividend, divisor, mem_rdata, cpu_halt, rsp_ready,
    output req_ready, mem_sel, mem_we, mem_addr, mem_wdata, cpu_start,
           rsp_valid, quotient, err_div0, err_timeout
  );

  modport slave (
    output req_valid, dividend, divisor, mem_rdata, cpu_halt, rsp_ready,
    input  req_ready, mem_sel, mem_we, mem_addr, mem_wdata, cpu_start,
           rsp_valid, quotient, err_div0, err_timeout
  );

endinterface

// File: rtl/div_run_ctrl_watchdog.sv
// Saturating 16-bit run-cycle counter; expired marks the last allowed
// processor cycle before the job is abandoned.
module run_watchdog #(
  parameter int MAX_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [15:0] o_count,
  output logic        o_expired
);

  logic [15:0] r_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count   = r_count;
  assign o_expired = (r_count == 16'(MAX_CYCLES - 1));

endmodule

// File: rtl/div_run_ctrl.sv
// Host-side sequencer: loads divide operands into processor memory, runs
// the program until halt (or watchdog expiry) and returns the quotient.
module div_run_ctrl
  import div_run_pkg::*;
#(
  parameter int MEM_AW     = 8,
  parameter int MAX_CYCLES = 4096
) (
  input  logic          CLK,
  input  logic          RESET_N,
  div_run_ctrl_if.master io_bus
);

  run_state_t  r_state;
  run_state_t  w_nextState;
  logic [2:0]  r_step;
  logic [15:0] r_dividend;
  logic [7:0]  r_divisor;
  logic [23:0] r_quotient;
  logic        r_errDiv0;
  logic        r_errTimeout;

  logic        w_reqReady;
  logic        w_memSel;
  logic        w_memWe;
  logic [2:0]  w_addr3;
  logic [7:0]  w_memWdata;
  logic        w_cpuStart;
  logic        w_rspValid;
  logic        w_wdClear;
  logic        w_wdEnable;
  logic        w_wdExpired;
  logic [15:0] w_wdCount;
  logic        w_haltSeen;

  run_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .i_clear   (w_wdClear),
    .i_enable  (w_wdEnable),
    .o_count   (w_wdCount),
    .o_expired (w_wdExpired)
  );

  // A halt still asserted from the previous job shows up in RUN cycle 0.
  assign w_haltSeen = io_bus.cpu_halt && (w_wdCount != 16'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 1'b0;
    w_memSel    = 1'b0;
    w_memWe     = 1'b0;
    w_addr3     = '0;
    w_memWdata  = '0;
    w_cpuStart  = 1'b1;
    w_rspValid  = 1'b0;
    w_wdClear   = 1'b0;
    w_wdEnable  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_reqReady = 1'b1;
        if (io_bus.req_valid) w_nextState = (io_bus.divisor == 8'd0) ? S_RESP : S_LOAD;
      end
      S_LOAD: begin
        w_memSel = 1'b1;
        w_memWe  = 1'b1;
        w_addr3  = loadAddr(r_step);
        case (r_step)
          3'd0:    w_memWdata = r_dividend[15:8];
          3'd1:    w_memWdata = r_dividend[7:0];
          3'd2:    w_memWdata = r_divisor;
          default: w_memWdata = 8'd0;
        endcase
        if (r_step == LOAD_LEN - 3'd1) begin
          w_nextState = S_RUN;
          w_wdClear   = 1'b1;
        end
      end
      S_RUN: begin
        w_cpuStart = 1'b0;
        w_wdEnable = 1'b1;
        if (w_haltSeen)       w_nextState = S_READ;
        else if (w_wdExpired) w_nextState = S_RESP;
      end
      S_READ: begin
        w_memSel = 1'b1;
        w_addr3  = ADDR_Q0 + r_step;
        if (r_step == READ_LEN - 3'd1) w_nextState = S_RESP;
      end
      S_RESP: begin
        w_rspValid = 1'b1;
        if (io_bus.rsp_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Quotient bytes arrive most-significant first from addresses 4, 5, 6.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_step       <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quotient   <= '0;
      r_errDiv0    <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_dividend   <= io_bus.dividend;
            r_divisor    <= io_bus.divisor;
            r_step       <= '0;
            r_errTimeout <= 1'b0;
            r_errDiv0    <= (io_bus.divisor == 8'd0);
            r_quotient   <= (io_bus.divisor == 8'd0) ? 24'hFFFFFF : 24'h000000;
          end
        end
        S_LOAD: r_step <= (r_step == LOAD_LEN - 3'd1) ? 3'd0 : r_step + 3'd1;
        S_RUN: begin
          if (!w_haltSeen && w_wdExpired) begin
            r_errTimeout <= 1'b1;
            r_quotient   <= '0;
          end
        end
        S_READ: begin
          case (r_step)
            3'd0:    r_quotient[23:16] <= io_bus.mem_rdata;
            3'd1:    r_quotient[15:8]  <= io_bus.mem_rdata;
            default: r_quotient[7:0]   <= io_bus.mem_rdata;
          endcase
          r_step <= (r_step == READ_LEN - 3'd1) ? 3'd0 : r_step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.req_ready   = w_reqReady;
  assign io_bus.mem_sel     = w_memSel;
  assign io_bus.mem_we      = w_memWe;
  assign io_bus.mem_addr    = MEM_AW'(w_addr3);
  assign io_bus.mem_wdata   = w_memWdata;
  assign io_bus.cpu_start   = w_cpuStart;
  assign io_bus.rsp_valid   = w_rspValid;
  assign io_bus.quotient    = r_quotient;
  assign io_bus.err_div0    = r_errDiv0;
  assign io_bus.err_timeout = r_errTimeout;

endmodule

// File: tb/tb_div_run_ctrl.sv
// Directed bench for div_run_ctrl with a behavioural processor that divides
// (mem[0:1]<<8)/mem[2] into mem[4..6] and halts a set number of cycles later.
module tb_div_run_ctrl;

  localparam int MAXC = 64;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   haltN = 20;
  logic hangMode = 1'b0;
  logic staleHalt = 1'b0;
  int   cpuCnt = 0;
  int   lat;
  int   bad;
  logic [7:0] mem [0:255];

  div_run_ctrl_if #(.MEM_AW(8)) bus();

  div_run_ctrl #(.MEM_AW(8), .MAX_CYCLES(MAXC)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .io_bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.cpu_halt  = !bus.cpu_start &&
                         ((!hangMode && (cpuCnt >= haltN - 1)) || (staleHalt && (cpuCnt == 0)));

  // Processor model: runs while start is low and writes its result one
  // cycle before raising halt.
  always @(posedge CLK) begin
    logic [23:0] q;
    if (bus.mem_sel && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.cpu_start) begin
      cpuCnt <= 0;
    end else begin
      cpuCnt <= cpuCnt + 1;
      if (!hangMode && (cpuCnt == haltN - 2)) begin
        q = {mem[0], mem[1], 8'h00} / {16'h0000, mem[2]};
        mem[4] <= q[23:16];
        mem[5] <= q[15:8];
        mem[6] <= q[7:0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one job at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
    checkOutput("reqReadyBeforeJob", 32'(bus.req_ready), 32'd1);
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.req_valid = 1'b1;
    @(negedge CLK);
    bus.req_valid = 1'b0;
  endtask

  task automatic checkLoad(input logic [15:0] dvd, input logic [7:0] dvs);
    logic [7:0] expA;
    logic [7:0] expD;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin expA = 8'd0; expD = dvd[15:8]; end
        1: begin expA = 8'd1; expD = dvd[7:0];  end
        2: begin expA = 8'd2; expD = dvs;       end
        default: begin expA = 8'(i + 1); expD = 8'd0; end
      endcase
      checkOutput($sformatf("load%0d", i),
                  {14'd0, bus.cpu_start, bus.mem_sel, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                  {14'd0, 1'b1, 1'b1, 1'b1, expA, expD});
      @(negedge CLK);
    end
  endtask

  // lat counts edges after the accepting edge until rsp_valid shows.
  task automatic waitRsp(input int startLat, input int limit, output int latOut);
    latOut = startLat;
    while ((bus.rsp_valid !== 1'b1) && (latOut < limit)) begin
      @(negedge CLK);
      latOut++;
    end
  endtask

  task automatic collect();
    checkOutput("reqReadyInResp", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    bus.rsp_ready = 1'b0;
    checkOutput("rspValidAfterHandshake", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctl"},
                {26'd0, bus.req_ready, bus.cpu_start, bus.mem_sel, bus.mem_we, bus.rsp_valid, 1'b0},
                {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    checkOutput({tag, "_addrData"}, {16'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state
    @(negedge CLK);
    checkResetValues("reset");
    checkOutput("resetResult", {6'd0, bus.err_div0, bus.err_timeout, bus.quotient}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Basic job: 0x0200/3 = 0xAA
    haltN = 20;
    applyStimulus(16'h0002, 8'd3);
    checkLoad(16'h0002, 8'd3);
    waitRsp(6, 200, lat);
    checkOutput("basicLat", 32'(lat), 32'd29);
    checkOutput("basicQ", 32'(bus.quotient), 32'h0000AA);
    checkOutput("basicFlags", {30'd0, bus.err_div0, bus.err_timeout}, 32'd0);
    checkOutput("basicStart", 32'(bus.cpu_start), 32'd1);
    collect();

    // Divide by zero
    applyStimulus(16'h1234, 8'd0);
    checkOutput("div0Rsp", 32'(bus.rsp_valid), 32'd1);
    checkOutput("div0Flags", {30'd0, bus.err_div0, bus.err_timeout}, 32'd2);
    checkOutput("div0Q", 32'(bus.quotient), 32'hFFFFFF);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_we || !bus.cpu_start) bad++;
      @(negedge CLK);
    end
    checkOutput("div0NoRun", 32'(bad), 32'd0);
    collect();

    // Hang: processor never halts, watchdog fires
    hangMode = 1'b1;
    applyStimulus(16'h1000, 8'd5);
    waitRsp(0, 300, lat);
    checkOutput("hangLat", 32'(lat), 32'(6 + MAXC));
    checkOutput("hangFlags", {30'd0, bus.err_div0, bus.err_timeout}, 32'd1);
    checkOutput("hangQ", 32'(bus.quotient), 32'd0);
    checkOutput("hangStart", 32'(bus.cpu_start), 32'd1);
    collect();
    hangMode = 1'b0;

    // Backpressure then back-to-back job
    haltN = 8;
    applyStimulus(16'hFFFF, 8'd1);
    waitRsp(0, 200, lat);
    checkOutput("bpLat", 32'(lat), 32'd17);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.rsp_valid || (bus.quotient !== 24'hFFFF00) || bus.err_div0 || bus.err_timeout) bad++;
      @(negedge CLK);
    end
    checkOutput("bpStable", 32'(bad), 32'd0);
    checkOutput("bpQ", 32'(bus.quotient), 32'hFFFF00);
    collect();
    applyStimulus(16'h0100, 8'h10);
    waitRsp(0, 200, lat);
    checkOutput("b2bLat", 32'(lat), 32'd17);
    checkOutput("b2bQ", 32'(bus.quotient), 32'h001000);
    collect();

    // Reset during LOAD step 3
    haltN = 20;
    applyStimulus(16'h0002, 8'd3);
    repeat (3) @(negedge CLK);
    checkOutput("midLoadWe", {24'd0, bus.mem_addr}, 32'd4);
    RESET_N = 1'b0;
    #1;
    checkResetValues("rstLoad");
    #2;
    RESET_N = 1'b1;
    @(negedge CLK);

    // Reset during RUN
    applyStimulus(16'h0002, 8'd3);
    repeat (8) @(negedge CLK);
    checkOutput("midRunStart", 32'(bus.cpu_start), 32'd0);
    RESET_N = 1'b0;
    #1;
    checkResetValues("rstRun");
    #2;
    RESET_N = 1'b1;
    @(negedge CLK);

    // Job after reset: 0x030000/7 = 0x6DB6
    applyStimulus(16'h0300, 8'd7);
    checkLoad(16'h0300, 8'd7);
    waitRsp(6, 200, lat);
    checkOutput("postRstLat", 32'(lat), 32'd29);
    checkOutput("postRstQ", 32'(bus.quotient), 32'h006DB6);
    collect();

    // Stale halt in first RUN cycle: 0x005000/3 = 0x1AAA
    haltN     = 10;
    staleHalt = 1'b1;
    applyStimulus(16'h0050, 8'd3);
    waitRsp(0, 200, lat);
    checkOutput("staleLat", 32'(lat), 32'd19);
    checkOutput("staleQ", 32'(bus.quotient), 32'h001AAA);
    collect();
    staleHalt = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_run_ctrl.md
# div_run_ctrl

- Synthesizable host-side sequencer that sits directly upstream of the TopLevel processor.
- Accepts a divide job, writes the operands into the processor's data memory, launches the program through `start`, waits for `halt`, then reads the 24-bit quotient back.
- Returns the result on a valid/ready response port.
- Replaces hand-preloading of data memory from the bench, so back-to-back jobs run in hardware.

## Interface
- `MEM_AW`, 8, data-memory address width.
- `MAX_CYCLES`, 4096, watchdog limit on processor run cycles. Must be ≥ 2 and < 2^16.
- `CLK`, in, 1, the only clock. All state updates on the rising edge.
- `RESET_N`, in, 1, active-low reset, asynchronous assert.
- `req_valid`, in, 1, a job is offered.
- `req_ready`, out, 1, the block can accept a job. High only in IDLE.
- `dividend`, in, 16, unsigned; sampled on acceptance.
- `divisor`, in, 8, unsigned; sampled on acceptance.
- `mem_sel`, out, 1, high when this block owns the data-memory port (LOAD, READ).
- `mem_we`, out, 1, write strobe.
- `mem_addr`, out, MEM_AW, memory address.
- `mem_wdata`, out, 8, write data.
- `mem_rdata`, in, 8, combinational (same-cycle) read data.
- `cpu_start`, out, 1, drives TopLevel `start`. High holds the processor in reset.
- `cpu_halt`, in, 1, TopLevel `halt`.
- `rsp_valid`, out, 1, result available.
- `rsp_ready`, in, 1, consumer takes the result.
- `quotient`, out, 24, holds {mem[4], mem[5], mem[6]}, i.e. (dividend<<8)/divisor.
- `err_div0`, out, 1, the job had divisor == 0.
- `err_timeout`, out, 1, the watchdog expired.

## Operation
- **States:** IDLE, LOAD, RUN, READ, RESP.
- **IDLE:** `req_ready`=1 and `cpu_start`=1. On `req_valid` the operands are latched.
  - divisor==0: go to RESP with `err_div0`=1 and `quotient`=24'hFFFFFF. No memory access and no run.
  - otherwise: go to LOAD.
- **LOAD:** 6 cycles. `mem_sel`=`mem_we`=1. The addr/data sequence is:
  - addr 0 ← dividend[15:8]
  - addr 1 ← dividend[7:0]
  - addr 2 ← divisor
  - addr 4, 5, 6 ← 0
  - Then go to RUN.
- **RUN:** `cpu_start`=0 and `mem_sel`=0. The cycle counter starts at 0 and increments every cycle.
  - `cpu_halt` is ignored in the first RUN cycle, to ignore any stale halt.
  - `cpu_halt`=1 afterwards: go to READ.
  - Counter reaches MAX_CYCLES-1 with no halt: go to RESP with `err_timeout`=1 and `quotient`=0.
  - If halt and the watchdog limit occur in the same cycle, halt wins.
- **READ:** 3 cycles. `mem_sel`=1, `mem_we`=0. Addresses 4, 5, 6 in turn; `mem_rdata` is captured into quotient[23:16], [15:8] and [7:0] at each edge. `cpu_start` returns to 1 on entry. Then go to RESP.
- **RESP:** `rsp_valid`=1. All result outputs stay stable until `rsp_valid && rsp_ready`, then the block returns to IDLE. Error flags clear on the next acceptance.
- Outputs when not in LOAD/READ: `mem_addr`=0, `mem_wdata`=0.

## Timing
- **Reset values:**
  - `req_ready`=1 and `cpu_start`=1.
  - `mem_sel`=`mem_we`=0, `mem_addr`=`mem_wdata`=0.
  - `rsp_valid`=0, `quotient`=0, both error flags=0.
  - State is IDLE.
- **Reset mid-job:** any state returns to IDLE immediately. `mem_we` drops asynchronously and no further writes occur. The processor is held via `cpu_start`=1.
- **Latency,** from the accepting edge to `rsp_valid`:
  - normal job: 6 + R + 3 cycles, where R is RUN cycles including the halt cycle.
  - div0 job: 1 cycle.
  - timeout job: 6 + MAX_CYCLES cycles.
- **Response:** `rsp_valid` stays high if `rsp_ready` is held low. A new job can be accepted no earlier than the cycle after the response handshake.
- **Counter:** 16-bit, saturates, and is reset on RUN entry.

## Structure
- Package `div_run_pkg` holds:
  - the state enum `run_state_t`
  - address constants `ADDR_DVD_HI`=0, `ADDR_DVD_LO`=1, `ADDR_DVS`=2, `ADDR_Q0`=4
  - `LOAD_LEN`=6 and `READ_LEN`=3.
- Sub-module `run_watchdog`: counter with clear, enable and `expired` output at MAX_CYCLES-1.
- Main FSM plus a 3-bit step index for LOAD/READ in `div_run_ctrl`.

## Test plan
The bench uses a behavioural CPU model: it computes (mem[0:1]<<8)/mem[2] into mem[4..6] and raises halt N cycles after start falls.

- **Basic job:** dividend=0x0002, divisor=3, N=20 → six writes (0x00, 0x02, 0x03, 0, 0, 0), then `quotient`=0x0000AA, flags 0, `rsp_valid` at accept+29.
- **Divide by zero:** divisor=0 → `rsp_valid` next cycle, `err_div0`=1, `quotient`=0xFFFFFF, `mem_we` never asserted, `cpu_start` never falls.
- **Hang:** MAX_CYCLES=64 and the model never halts → `err_timeout`=1, `quotient`=0, `cpu_start` back to 1.
- **Backpressure and back-to-back:** `rsp_ready` low for 10 cycles, then jobs 0xFFFF/1 and 0x0100/0x10 → outputs stable while stalled; results 0xFFFF00 then 0x001000.
- **Reset mid-job:** `RESET_N` pulsed low in LOAD step 3 and again in RUN → all outputs at reset values at once, the next job completes correctly.
- **Stale halt:** halt held high during the first RUN cycle only → it is ignored and the block waits for the true halt.
